// File: rtl/cs_resolve_pkg.sv
// ============================================================================
// Module  : cs_resolve_pkg
// Purpose : Shared FSM state type and sizing helpers for cs_resolve_seq.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cs_resolve_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A single-chunk build still needs a 1-bit index register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cs_chunk_add.sv
// ============================================================================
// Module  : cs_chunk_add
// Purpose : Combinational W-bit add with carry-in/carry-out (one resolve slice).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cs_chunk_add #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum,
  output logic         o_cout
);

  // Kept as a plain '+' so synthesis picks its own adder cells.
  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};

endmodule

`default_nettype wire

// File: rtl/cs_resolve_seq.sv
// ============================================================================
// Module  : cs_resolve_seq
// Purpose : Sequential carry-save to binary resolver, CHUNK bits per cycle.
//           Optional subtract mode enabled by defining CS_RESOLVE_SUB_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cs_resolve_seq
  import cs_resolve_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_carry,
`ifdef CS_RESOLVE_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_result
);

  localparam int c_nchunk = nchunk(WIDTH, CHUNK);
  localparam int c_idx_w  = idx_width(c_nchunk);
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_nchunk - 1);

  state_t             r_state;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [WIDTH:0]     r_result;
  logic [WIDTH-1:0]   r_sum_op;
  logic [WIDTH-1:0]   r_carry_op;
  logic [c_idx_w-1:0] r_idx;
  logic               r_cy;
  logic               r_sub;

  logic               w_in_sub;
  logic [CHUNK-1:0]   w_sum_chunk;
  logic [CHUNK-1:0]   w_carry_chunk;
  logic [CHUNK-1:0]   w_res_chunk;
  logic               w_cout;

`ifdef CS_RESOLVE_SUB_EN
  assign w_in_sub = in_sub;
`else
  assign w_in_sub = 1'b0;
`endif

  // Subtraction is a + ~b + 1: invert every carry chunk, seed carry with 1.
  assign w_sum_chunk   = r_sum_op[CHUNK*int'(r_idx) +: CHUNK];
  assign w_carry_chunk = r_carry_op[CHUNK*int'(r_idx) +: CHUNK] ^ {CHUNK{r_sub}};

  cs_chunk_add #(
    .W (CHUNK)
  ) u_chunk_add (
    .i_a    (w_sum_chunk),
    .i_b    (w_carry_chunk),
    .i_cin  (r_cy),
    .o_sum  (w_res_chunk),
    .o_cout (w_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_sum_op    <= '0;
      r_carry_op  <= '0;
      r_idx       <= '0;
      r_cy        <= 1'b0;
      r_sub       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sum_op   <= in_sum;
            r_carry_op <= in_carry;
            r_sub      <= w_in_sub;
            r_cy       <= w_in_sub;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= BUSY;
          end
        end
        BUSY: begin
          r_result[CHUNK*int'(r_idx) +: CHUNK] <= w_res_chunk;
          r_cy  <= w_cout;
          r_idx <= r_idx + 1'b1;
          if (r_idx == c_last_idx) begin
            r_result[WIDTH] <= w_cout;
            r_out_valid     <= 1'b1;
            r_state         <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_cs_resolve_seq.sv
// ============================================================================
// Module  : tb_cs_resolve_seq
// Purpose : Directed self-checking bench for cs_resolve_seq (32/8 and 16/16).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cs_resolve_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_sum;
  logic [31:0] in_carry;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [32:0] out_result;

  logic        s_in_valid;
  logic        s_in_ready;
  logic [15:0] s_in_sum;
  logic [15:0] s_in_carry;
  logic        s_out_valid;
  logic [16:0] s_out_result;

  int errors;
  int checks;

  cs_resolve_seq #(.WIDTH(32), .CHUNK(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sum     (in_sum),
    .in_carry   (in_carry),
`ifdef CS_RESOLVE_SUB_EN
    .in_sub     (in_sub),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  cs_resolve_seq #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (s_in_valid),
    .in_ready   (s_in_ready),
    .in_sum     (s_in_sum),
    .in_carry   (s_in_carry),
`ifdef CS_RESOLVE_SUB_EN
    .in_sub     (1'b0),
`endif
    .out_valid  (s_out_valid),
    .out_ready  (1'b1),
    .out_result (s_out_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents an operand pair, waits for acceptance then for out_valid.
  // lat counts clock edges from the accepting edge (inclusive) to out_valid.
  task automatic do_op(input logic [31:0] s, input logic [31:0] c,
                       output int lat, output logic [32:0] res, output time t_hs);
    int n;
    in_sum   = s;
    in_carry = c;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk);
    t_hs = $time;
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    res = out_result;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    checks++;
    if (out_result !== 33'h0) begin
      errors++; $display("FAIL reset_out_result: got %h want 0", out_result);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_add;
    int lat; logic [32:0] res; time t;
    out_ready = 1'b1;
    do_op(32'h0000_00FF, 32'h0000_0001, lat, res, t);
    checks++;
    if (res !== 33'h0_0000_0100) begin
      errors++; $display("FAIL basic_result: got %h want 000000100", res);
    end
    checks++;
    if (lat !== 5) begin
      errors++; $display("FAIL basic_latency: got %0d want 5", lat);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_release: got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_ripple;
    logic [31:0] vs [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 32'h8080_8080};
    logic [31:0] vc [4] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 32'h8080_8080};
    logic [32:0] ve [4] = '{33'h1_0000_0000, 33'h1_FFFF_FFFE, 33'h0_2143_6587, 33'h1_0101_0100};
    int lat; logic [32:0] res; time t;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_op(vs[i], vc[i], lat, res, t);
      checks++;
      if (res !== ve[i]) begin
        errors++; $display("FAIL ripple_%0d: got %h want %h", i, res, ve[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    int lat; logic [32:0] res; time t;
    out_ready = 1'b0;
    do_op(32'hAAAA_0000, 32'h0000_5555, lat, res, t);
    checks++;
    if (res !== 33'h0_AAAA_5555) begin
      errors++; $display("FAIL bp_result: got %h want 0aaaa5555", res);
    end
    in_sum = 32'h1; in_carry = 32'h1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_result !== 33'h0_AAAA_5555 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold_%0d: got res=%h ready=%b valid=%b want res=0aaaa5555 ready=0 valid=1",
                 i, out_result, in_ready, out_valid);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
    end
    do_op(32'h1, 32'h1, lat, res, t);
    checks++;
    if (res !== 33'h2 || lat !== 5) begin
      errors++; $display("FAIL bp_next: got res=%h lat=%0d want res=2 lat=5", res, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_busy;
    int seen;
    out_ready = 1'b1;
    in_sum = 32'hFFFF_FFFF; in_carry = 32'h0000_0003; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== 33'h0) begin
      errors++;
      $display("FAIL midreset_state: got ready=%b valid=%b res=%h want ready=1 valid=0 res=0",
               in_ready, out_valid, out_result);
    end
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL midreset_spurious: got %0d valid cycles want 0", seen);
    end
  endtask

  task automatic test_back_to_back;
    int lat; logic [32:0] res; time t0, t1;
    out_ready = 1'b1;
    do_op(32'h0000_0010, 32'h0000_0020, lat, res, t0);
    do_op(32'h0001_0000, 32'h0002_0000, lat, res, t1);
    checks++;
    if ((t1 - t0) / 10 !== 6) begin
      errors++; $display("FAIL b2b_period: got %0d cycles want 6", (t1 - t0) / 10);
    end
    checks++;
    if (res !== 33'h0_0003_0000) begin
      errors++; $display("FAIL b2b_result: got %h want 000030000", res);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_full_chunk;
    logic [15:0] vs [2] = '{16'h8000, 16'hFFFF};
    logic [15:0] vc [2] = '{16'h8000, 16'hFFFF};
    logic [16:0] ve [2] = '{17'h1_0000, 17'h1_FFFE};
    int lat;
    for (int i = 0; i < 2; i++) begin
      s_in_sum = vs[i]; s_in_carry = vc[i]; s_in_valid = 1'b1;
      lat = 0;
      while (!s_in_ready && lat < 40) begin
        @(posedge clk); #1;
        lat++;
      end
      @(posedge clk); #1;
      s_in_valid = 1'b0;
      lat = 1;
      while (!s_out_valid && lat < 40) begin
        @(posedge clk); #1;
        lat++;
      end
      checks++;
      if (s_out_result !== ve[i] || lat !== 2) begin
        errors++;
        $display("FAIL w16_%0d: got res=%h lat=%0d want res=%h lat=2", i, s_out_result, lat, ve[i]);
      end
      @(posedge clk); #1;
    end
  endtask

`ifdef CS_RESOLVE_SUB_EN
  task automatic test_sub;
    int lat; logic [32:0] res; time t;
    out_ready = 1'b1;
    in_sub = 1'b1;
    do_op(32'd5, 32'd7, lat, res, t);
    checks++;
    if (res !== 33'h0_FFFF_FFFE || lat !== 5) begin
      errors++; $display("FAIL sub_borrow: got res=%h lat=%0d want res=0fffffffe lat=5", res, lat);
    end
    do_op(32'd7, 32'd5, lat, res, t);
    checks++;
    if (res !== 33'h1_0000_0002) begin
      errors++; $display("FAIL sub_noborrow: got %h want 100000002", res);
    end
    in_sub = 1'b0;
    do_op(32'd7, 32'd5, lat, res, t);
    checks++;
    if (res !== 33'h0_0000_000C) begin
      errors++; $display("FAIL sub_off_add: got %h want 00000000c", res);
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    errors = 0; checks = 0;
    in_valid = 1'b0; in_sum = '0; in_carry = '0; in_sub = 1'b0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_in_sum = '0; s_in_carry = '0;
    rst_n = 1'b0;
    test_reset;
    test_basic_add;
    test_ripple;
    test_backpressure;
    test_reset_mid_busy;
    test_back_to_back;
    test_full_chunk;
`ifdef CS_RESOLVE_SUB_EN
    test_sub;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
